// File: rtl/mul_div_unit_if.sv
// Controller-side bundle for the multiply/divide unit: operation request,
// MTHI/MTLO writes, and HI/LO/status readback.
`timescale 1ns/1ps
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit holding the MIPS HI/LO registers.
// Works on magnitudes; the sign fix-up is applied once, in FIN.
`timescale 1ns/1ps
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               w_busy, w_last;
  logic               r_done, r_is_div, r_neg_q, r_neg_r;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q, r_b, r_hi, r_lo;

  // Operand conditioning: op[0] selects signed, op[1] selects divide.
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  assign w_a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign w_b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign w_abs_a = w_a_neg ? -bus.a : bus.a;
  assign w_abs_b = w_b_neg ? -bus.b : bus.b;

  // One iteration: {r_acc, r_q} is the product/remainder:quotient pair.
  logic [WIDTH:0]     w_sum, w_shift, w_acc_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_ge;
  assign w_sum     = r_q[0] ? (r_acc + {1'b0, r_b}) : r_acc;
  assign w_shift   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_acc_nxt = r_is_div ? (w_ge ? (w_shift - {1'b0, r_b}) : w_shift)
                              : {1'b0, w_sum[WIDTH:1]};
  assign w_q_nxt   = r_is_div ? {r_q[WIDTH-2:0], w_ge}
                              : {w_sum[0], r_q[WIDTH-1:1]};

  // Divide by zero leaves quotient all ones and remainder = latched |a|; keep them raw.
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_rem, w_quo_fix, w_rem_fix, w_hi_res, w_lo_res;
  logic               w_div0;
  assign w_prod     = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_rem      = r_acc[WIDTH-1:0];
  assign w_div0     = (r_b == '0);
  assign w_quo_fix  = (r_neg_q && !w_div0) ? -r_q  : r_q;
  assign w_rem_fix  = (r_neg_r && !w_div0) ? -w_rem : w_rem;
  assign w_hi_res   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_res   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN:   if (w_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_is_div <= bus.op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= bus.op[1] & w_a_neg;
            r_q      <= w_abs_a;
            r_b      <= w_abs_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end else begin
            if (bus.hi_we) r_hi <= bus.wd;
            if (bus.lo_we) r_lo <= bus.wd;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIN: begin
          r_hi   <= w_hi_res;
          r_lo   <= w_lo_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, holding the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU one bit per cycle. It also services MTHI/MTLO writes and drives MFHI/MFLO reads.
- Sits beside the ALU. The controller stalls on busy before reading HI/LO or issuing another operation.

Parameters:
WIDTH, 32, operand and HI/LO width in bits; legal values are >= 4.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  multiplicand or dividend (rs)
b  input  WIDTH  multiplier or divisor (rt)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wd  input  WIDTH  MTHI/MTLO write data
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO have been updated by an operation
hi  output  WIDTH  HI register (product upper half or remainder)
lo  output  WIDTH  LO register (product lower half or quotient)

Behaviour:
- Reset (any time, including mid-operation):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Any operation in flight is discarded.
- States: IDLE, RUN, FIN.
- IDLE:
  - On a clock edge with start=1: latch op; latch |a| and |b| (absolute values for signed ops, raw values for unsigned ops); record the result sign(s).
  - Clear the working accumulator and counter, then go to RUN. busy=1 from this edge.
- RUN:
  - One radix-2 iteration per edge: shift-add for multiply, restoring shift-subtract for divide.
  - The counter increments each edge. After the WIDTH-th iteration edge, go to FIN.
- FIN:
  - On the next edge, apply the sign fix-up and write hi/lo.
  - Set done=1 for exactly one cycle and busy=0, then go to IDLE.
- Latency: the start edge is edge 0. hi/lo are updated and done rises at edge WIDTH+1. busy is high between edge 0 and edge WIDTH+1.
- A new start is accepted on the edge at which done is high.
- Multiply:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT is two's-complement: the magnitude product is negated when operand signs differ.
- Divide:
  - lo = quotient, hi = remainder.
  - DIV truncates toward zero: the quotient is negative when signs differ; the remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU): lo = all ones, hi = a as latched. No exception or flag.
- DIV of the most negative value by -1: lo = most negative value, hi = 0 (wraps; no trap).
- hi_we/lo_we:
  - Honoured only in IDLE with start=0.
  - hi <= wd and/or lo <= wd on that edge; both may fire together.
  - Ignored while busy. If start=1 in the same IDLE cycle, start wins and the writes are dropped.
- start while busy: ignored. Operands a/b/op may change freely after edge 0.
- hi/lo hold their previous values during RUN and change only at FIN, reset, or an honoured write.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high edges 0..32, done pulse after edge 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- During a running DIVU 1000/7, pulse start with op=MULTU and pulse hi_we with wd=0xDEADBEEF -> both ignored; result lo=142, hi=6.
- In IDLE, lo_we=1 with wd=0x12345678 -> lo=0x12345678, hi unchanged. The same cycle with start=1 -> write dropped, operation starts.
- Assert reset at edge 10 of a MULT -> hi=lo=0, busy=0, no done pulse. A fresh MULTU 6*7 afterwards -> lo=42, hi=0.
